// File: rtl/bsg_nasti_serial_responder.sv
// Target-side end of the serialized NASTI tunnel: expands sa/sw packets into AR/AW/W
// and folds B/R back into sr packets. Address packet = {addr,len,size,burst,lock,cache,prot,qos,region,id}.
module bsg_nasti_serial_responder #(
   parameter int burst_len_p  = 7,
   parameter int max_rd_out_p = 4
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        sa_v_i,
   input  logic [38:0] sa_data_i,
   output logic        sa_ready_o,
   input  logic        sw_v_i,
   input  logic [64:0] sw_data_i,
   output logic        sw_ready_o,
   output logic        ar_v_o,
   output logic [66:0] ar_data_o,
   input  logic        ar_ready_i,
   output logic        aw_v_o,
   output logic [66:0] aw_data_o,
   input  logic        aw_ready_i,
   output logic        w_v_o,
   output logic [72:0] w_data_o,
   input  logic        w_ready_i,
   input  logic        b_v_i,
   input  logic [7:0]  b_data_i,
   output logic        b_ready_o,
   input  logic        r_v_i,
   input  logic [72:0] r_data_i,
   output logic        r_ready_o,
   output logic        sr_v_o,
   output logic [70:0] sr_data_o,
   input  logic        sr_ready_i,
   output logic        error_o
);
   localparam int cnt_w = (burst_len_p > 0) ? $clog2(burst_len_p + 1) : 1;
   localparam int rd_w  = $clog2(max_rd_out_p + 1);
   localparam logic [cnt_w-1:0] last_beat = cnt_w'(burst_len_p);
   localparam logic [rd_w-1:0]  rd_max    = rd_w'(max_rd_out_p);

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic        lock;
      logic [3:0]  cache;
      logic [2:0]  prot;
      logic [3:0]  qos;
      logic [3:0]  region;
      logic [5:0]  id;
   } nasti_addr_s;

   typedef struct packed {
      logic [1:0]  resp;
      logic [63:0] data;
      logic        last;
      logic [5:0]  id;
   } nasti_r_s;

   typedef enum logic [1:0] {e_idle, e_ar, e_aw, e_w} req_state_e;
   typedef enum logic       {e_ridle, e_rburst}        rsp_state_e;

   req_state_e        req_state;
   rsp_state_e        rsp_state;
   logic [31:0]       addr_r;
   logic [5:0]        id_r;
   logic [cnt_w-1:0]  beat_cnt;
   logic [rd_w-1:0]   rd_cnt;
   nasti_addr_s       a_pkt;
   nasti_r_s          r_pkt;
   logic              sw_last, beat_is_last;
   logic              sa_hs, ar_hs, aw_hs, w_hs, r_hs;
   logic              rd_inc, rd_dec;

   assign r_pkt        = nasti_r_s'(r_data_i);
   assign sw_last      = sw_data_i[64];
   assign beat_is_last = (beat_cnt == last_beat);

   always_comb begin
      a_pkt        = '0;
      a_pkt.addr   = addr_r;
      a_pkt.len    = 8'(burst_len_p);
      a_pkt.size   = 3'd3;
      a_pkt.burst  = 2'b01;
      a_pkt.id     = id_r;
   end

   assign ar_data_o  = a_pkt;
   assign aw_data_o  = a_pkt;
   assign sa_ready_o = (req_state == e_idle);
   assign ar_v_o     = (req_state == e_ar) && (rd_cnt < rd_max);
   assign aw_v_o     = (req_state == e_aw);
   // W is a zero-latency pass of the sw stream; framing comes from the beat counter
   assign w_v_o      = (req_state == e_w) && sw_v_i;
   assign sw_ready_o = (req_state == e_w) && w_ready_i;
   assign w_data_o   = {sw_data_i[63:0], beat_is_last, 8'hFF};

   assign sa_hs = sa_v_i & sa_ready_o;
   assign ar_hs = ar_v_o & ar_ready_i;
   assign aw_hs = aw_v_o & aw_ready_i;
   assign w_hs  = w_v_o & w_ready_i;
   assign r_hs  = r_v_i & r_ready_o;

   // B wins only between R bursts so an R burst is never split by a B packet
   always_comb begin
      sr_v_o    = 1'b0;
      sr_data_o = '0;
      b_ready_o = 1'b0;
      r_ready_o = 1'b0;
      if (rsp_state == e_ridle && b_v_i) begin
         sr_v_o    = 1'b1;
         sr_data_o = {1'b1, 62'b0, b_data_i[7:6], b_data_i[5:0]};
         b_ready_o = sr_ready_i;
      end else if (r_v_i) begin
         sr_v_o    = 1'b1;
         sr_data_o = {r_pkt.last, r_pkt.data, r_pkt.id};
         r_ready_o = sr_ready_i;
      end
   end

   assign rd_inc = ar_hs;
   assign rd_dec = r_hs & r_pkt.last;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         req_state <= e_idle;
         rsp_state <= e_ridle;
         addr_r    <= '0;
         id_r      <= '0;
         beat_cnt  <= '0;
         rd_cnt    <= '0;
         error_o   <= 1'b0;
      end else begin
         case (req_state)
            e_idle: if (sa_hs) begin
               addr_r    <= sa_data_i[38:7];
               id_r      <= sa_data_i[6:1];
               req_state <= sa_data_i[0] ? e_aw : e_ar;
            end
            e_ar: if (ar_hs) req_state <= e_idle;
            e_aw: if (aw_hs) begin
               beat_cnt  <= '0;
               req_state <= e_w;
            end
            e_w: if (w_hs) begin
               beat_cnt <= beat_cnt + cnt_w'(1);
               if (beat_is_last) req_state <= e_idle;
            end
            default: req_state <= e_idle;
         endcase

         case (rsp_state)
            e_ridle:  if (r_hs && !r_pkt.last) rsp_state <= e_rburst;
            e_rburst: if (r_hs && r_pkt.last)  rsp_state <= e_ridle;
            default:  rsp_state <= e_ridle;
         endcase

         if (rd_inc && !rd_dec)
            rd_cnt <= rd_cnt + rd_w'(1);
         else if (rd_dec && !rd_inc && rd_cnt != '0)
            rd_cnt <= rd_cnt - rd_w'(1);

         if ((w_hs && (sw_last != beat_is_last)) ||
             (r_hs && (r_pkt.resp != 2'b00)) ||
             (rd_dec && !rd_inc && rd_cnt == '0))
            error_o <= 1'b1;
      end
   end
endmodule
